// File: rtl/spi_lcd_pkg.sv
// Shared constants and FSM state type for the SPI LCD receiver.
package spi_lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    StIdle,
    StCaset,
    StPaset,
    StRamwr,
    StIgnore
  } lcd_state_e;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronises the pins into i_clk, detects SCK rising edges and
// assembles MSB-first bytes; flags a CS release that leaves a partial byte behind.
module spi_byte_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_dc,
  input  logic       i_cs,
  output logic [7:0] o_byte,
  output logic       o_dc,
  output logic       o_byte_valid,
  output logic       o_partial_abort
);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, dc_sync, cs_sync;
  logic                   sclk_prev, cs_prev;
  logic [6:0]             shift_q;
  logic [2:0]             bit_cnt_q;
  logic                   sclk_s, mosi_s, dc_s, cs_s;
  logic                   sck_rise, cs_rise;

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sclk_s & ~sclk_prev & ~cs_s;
  assign cs_rise  = cs_s & ~cs_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync       <= '0;
      mosi_sync       <= '0;
      dc_sync         <= '0;
      cs_sync         <= '1;  // bus idles deselected
      sclk_prev       <= 1'b0;
      cs_prev         <= 1'b1;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      o_byte          <= '0;
      o_dc            <= 1'b0;
      o_byte_valid    <= 1'b0;
      o_partial_abort <= 1'b0;
    end else begin
      sclk_sync       <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      mosi_sync       <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      dc_sync         <= {dc_sync[SYNC_STAGES-2:0], i_dc};
      cs_sync         <= {cs_sync[SYNC_STAGES-2:0], i_cs};
      sclk_prev       <= sclk_s;
      cs_prev         <= cs_s;
      o_byte_valid    <= 1'b0;
      o_partial_abort <= cs_rise && (bit_cnt_q != 3'd0);
      if (cs_s) begin
        bit_cnt_q <= '0;
      end else if (sck_rise) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          o_byte       <= {shift_q, mosi_s};
          o_dc         <= dc_s;
          o_byte_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_lcd_rx.sv
// SPI LCD display-side receiver: decodes CASET/PASET/RAMWR into pixel writes.
// Optional sticky protocol-error flag enabled by defining SPI_LCD_RX_ERR_EN.
module spi_lcd_rx
  import spi_lcd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned X_W         = 9,
  parameter int unsigned Y_W         = 9
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_sclk,
  input  logic           i_mosi,
  input  logic           i_dc,
  input  logic           i_cs,
  output logic           o_px_valid,
  output logic [X_W-1:0] o_px_x,
  output logic [Y_W-1:0] o_px_y,
  output logic [15:0]    o_px_color,
  output logic           o_cmd_valid,
  output logic [7:0]     o_cmd,
  output logic           o_err
);

  logic [7:0]     rx_byte;
  logic           rx_dc, rx_valid, rx_abort;
  lcd_state_e     state;
  logic [1:0]     param_idx;
  logic [23:0]    param_buf;
  logic [X_W-1:0] xs, xe, x_cnt;
  logic [Y_W-1:0] ys, ye, y_cnt;
  logic           hi_pending;
  logic [7:0]     color_hi;
  logic [15:0]    param_start, param_end;
  logic           x_last, y_last;

  spi_byte_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_byte_rx (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_sclk         (i_sclk),
    .i_mosi         (i_mosi),
    .i_dc           (i_dc),
    .i_cs           (i_cs),
    .o_byte         (rx_byte),
    .o_dc           (rx_dc),
    .o_byte_valid   (rx_valid),
    .o_partial_abort(rx_abort)
  );

  assign param_start = param_buf[23:8];
  assign param_end   = {param_buf[7:0], rx_byte};
  // An inverted window collapses that axis to its start coordinate.
  assign x_last      = (x_cnt == xe) || (xs > xe);
  assign y_last      = (y_cnt == ye) || (ys > ye);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= StIdle;
      param_idx   <= '0;
      param_buf   <= '0;
      xs          <= '0;
      xe          <= '0;
      ys          <= '0;
      ye          <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      hi_pending  <= 1'b0;
      color_hi    <= '0;
      o_px_valid  <= 1'b0;
      o_px_x      <= '0;
      o_px_y      <= '0;
      o_px_color  <= '0;
      o_cmd_valid <= 1'b0;
      o_cmd       <= '0;
    end else begin
      o_px_valid  <= 1'b0;
      o_cmd_valid <= 1'b0;
      if (rx_valid && !rx_dc) begin
        o_cmd_valid <= 1'b1;
        o_cmd       <= rx_byte;
        param_idx   <= '0;
        hi_pending  <= 1'b0;
        case (rx_byte)
          CMD_CASET: state <= StCaset;
          CMD_PASET: state <= StPaset;
          CMD_RAMWR: begin
            state <= StRamwr;
            x_cnt <= xs;
            y_cnt <= ys;
          end
          default:   state <= StIgnore;
        endcase
      end else if (rx_valid) begin
        case (state)
          StCaset, StPaset: begin
            param_buf <= {param_buf[15:0], rx_byte};
            param_idx <= param_idx + 2'd1;
            if (param_idx == 2'd3) begin
              if (state == StCaset) begin
                xs <= X_W'(param_start);
                xe <= X_W'(param_end);
              end else begin
                ys <= Y_W'(param_start);
                ye <= Y_W'(param_end);
              end
              state <= StIdle;
            end
          end
          StRamwr: begin
            if (!hi_pending) begin
              color_hi   <= rx_byte;
              hi_pending <= 1'b1;
            end else begin
              hi_pending <= 1'b0;
              o_px_valid <= 1'b1;
              o_px_x     <= x_cnt;
              o_px_y     <= y_cnt;
              o_px_color <= {color_hi, rx_byte};
              if (x_last) begin
                x_cnt <= xs;
                y_cnt <= y_last ? ys : y_cnt + 1'b1;
              end else begin
                x_cnt <= x_cnt + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_LCD_RX_ERR_EN
  logic err_q, wrapped_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q     <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      if (rx_valid && !rx_dc) begin
        wrapped_q <= 1'b0;
        if (state == StCaset || state == StPaset || (state == StRamwr && hi_pending)) begin
          err_q <= 1'b1;
        end
      end else if (rx_valid && state == StRamwr && hi_pending) begin
        // A pixel after the window has fully wrapped overwrites earlier data.
        if (wrapped_q) begin
          err_q <= 1'b1;
        end
        if (x_last && y_last) begin
          wrapped_q <= 1'b1;
        end
      end
      if (rx_abort) begin
        err_q <= 1'b1;
      end
    end
  end

  assign o_err = err_q;
`else
  logic unused_abort;
  assign unused_abort = rx_abort;
  assign o_err        = 1'b0;
`endif

endmodule
